// File: rtl/riscv_pkg.sv
// Shared fetch-stage types: FSM state encoding, base RV32I major opcodes, default reset PC.
package riscv_pkg;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_KILL = 2'd2
   } fetch_state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   function automatic logic opcode_known(input logic [6:0] op);
      case (op)
         OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: return 1'b1;
         default:                           return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's memory, decode and redirect signals.
// master = fetch unit side; slave = memory/decode/branch-resolution side.
interface fetch_unit_if #(
   parameter int DW = 32,
   parameter int AW = 32
);
   logic          imem_req_valid;
   logic          imem_req_ready;
   logic [AW-1:0] imem_addr;
   logic          imem_rsp_valid;
   logic [DW-1:0] imem_rdata;
   logic          inst_valid;
   logic          inst_ready;
   logic [DW-1:0] inst;
   logic [AW-1:0] inst_pc;
   logic [6:0]    opcode;
   logic [2:0]    func3;
   logic          func7_5;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          redirect_misaligned;

   modport master (
      output imem_req_valid, imem_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rdata,
      output inst_valid, inst, inst_pc, opcode, func3, func7_5,
      input  inst_ready,
      input  redirect_valid, redirect_pc,
      output redirect_misaligned
   );

   modport slave (
      input  imem_req_valid, imem_addr,
      output imem_req_ready, imem_rsp_valid, imem_rdata,
      input  inst_valid, inst, inst_pc, opcode, func3, func7_5,
      output inst_ready,
      output redirect_valid, redirect_pc,
      input  redirect_misaligned
   );
endinterface

// File: rtl/fetch_out_buf.sv
// Single-entry valid/ready holding register for a fetched word and its PC.
// Flush wins over load, load wins over drain.
module fetch_out_buf #(
   parameter int DW = 32,
   parameter int AW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_load,
   input  logic          i_flush,
   input  logic          i_ready,
   input  logic [DW-1:0] i_data,
   input  logic [AW-1:0] i_pc,
   output logic          o_valid,
   output logic [DW-1:0] o_data,
   output logic [AW-1:0] o_pc
);

   logic          r_valid;
   logic [DW-1:0] r_data;
   logic [AW-1:0] r_pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_pc    <= '0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
         r_pc    <= i_pc;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, one-outstanding-request FSM toward imem, redirect handling,
// and a single-entry output buffer toward decode with opcode/func field slices.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter int            DW       = 32,
   parameter int            AW       = 32,
   parameter logic [AW-1:0] RESET_PC = AW'(DEFAULT_RESET_PC)
) (
   input logic         clk,
   input logic         rst,
   fetch_unit_if.master fu
);

   fetch_state_t  r_state;
   fetch_state_t  w_state_nxt;
   logic [AW-1:0] r_pc;
   logic [AW-1:0] w_pc_nxt;
   logic [AW-1:0] w_pc_inc;
   logic [AW-1:0] w_redirect_pc;
   logic          r_misaligned;
   logic          w_req_valid;
   logic          w_req_fire;
   logic          w_load;
   logic          w_flush;
   logic          w_inst_valid;
   logic [DW-1:0] w_inst;
   logic [AW-1:0] w_inst_pc;

   // Only request when the buffer is empty or draining, so a response always finds a free slot.
   assign w_req_valid   = !rst && (r_state == S_REQ) && (!w_inst_valid || fu.inst_ready);
   assign w_req_fire    = w_req_valid && fu.imem_req_ready;
   assign w_pc_inc      = r_pc + AW'(4);
   assign w_redirect_pc = {fu.redirect_pc[AW-1:2], 2'b00};

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_load      = 1'b0;
      w_flush     = 1'b0;
      if (fu.redirect_valid) begin
         // A request to the old PC that is (or becomes) in flight must be drained in S_KILL.
         w_flush  = 1'b1;
         w_pc_nxt = w_redirect_pc;
         case (r_state)
            S_REQ:          w_state_nxt = w_req_fire ? S_KILL : S_REQ;
            S_WAIT, S_KILL: w_state_nxt = fu.imem_rsp_valid ? S_REQ : S_KILL;
            default:        w_state_nxt = S_REQ;
         endcase
      end else begin
         case (r_state)
            S_REQ: begin
               if (w_req_fire) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
               if (fu.imem_rsp_valid) begin
                  w_load      = 1'b1;
                  w_pc_nxt    = w_pc_inc;
                  w_state_nxt = S_REQ;
               end
            end
            S_KILL: begin
               if (fu.imem_rsp_valid) w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_REQ;
         r_pc         <= RESET_PC;
         r_misaligned <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         if (fu.redirect_valid) r_misaligned <= |fu.redirect_pc[1:0];
      end
   end

   // A response with no request outstanding is a memory protocol violation; it is ignored.
   always_ff @(posedge clk) begin
      if (!rst && r_state == S_REQ) assert (!fu.imem_rsp_valid);
   end

   fetch_out_buf #(
      .DW(DW),
      .AW(AW)
   ) u_out_buf (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_flush (w_flush),
      .i_ready (fu.inst_ready),
      .i_data  (fu.imem_rdata),
      .i_pc    (r_pc),
      .o_valid (w_inst_valid),
      .o_data  (w_inst),
      .o_pc    (w_inst_pc)
   );

   assign fu.imem_req_valid      = w_req_valid;
   assign fu.imem_addr           = r_pc;
   assign fu.inst_valid          = w_inst_valid;
   assign fu.inst                = w_inst;
   assign fu.inst_pc             = w_inst_pc;
   assign fu.opcode              = w_inst[6:0];
   assign fu.func3               = w_inst[14:12];
   assign fu.func7_5             = w_inst[30];
   assign fu.redirect_misaligned = r_misaligned;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard of expected request addresses and delivered
// instructions, plus a second instance with RESET_PC at the top of the address space.
module tb_fetch_unit;
   import riscv_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a;
   logic rst_b;

   fetch_unit_if #(.DW(32), .AW(32)) ifa ();
   fetch_unit_if #(.DW(32), .AW(32)) ifb ();

   fetch_unit #(.DW(32), .AW(32), .RESET_PC(32'h0000_0000)) u_dut (
      .clk (clk),
      .rst (rst_a),
      .fu  (ifa)
   );

   fetch_unit #(.DW(32), .AW(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk (clk),
      .rst (rst_b),
      .fu  (ifb)
   );

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_addr_q[$];
   logic [63:0] exp_inst_q[$];
   logic [63:0] mon_e;

   function automatic logic [31:0] memword(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0050_0093;
         32'h0000_0004: return 32'h4020_8133;
         default:       return {a[24:0], 7'b0010011} ^ 32'h4000_5000;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_pc(input string tag, input logic [31:0] pc);
      int n;
      n = 0;
      while (!(ifa.inst_valid === 1'b1 && ifa.inst_pc === pc) && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 64'(ifa.inst_pc), 64'(pc));
      chk({tag, "_valid"}, 64'(ifa.inst_valid), 64'(1));
   endtask

   // 1-cycle instruction memories, reset with their fetch unit
   always @(posedge clk) begin
      if (rst_a) ifa.imem_rsp_valid <= 1'b0;
      else       ifa.imem_rsp_valid <= ifa.imem_req_valid && ifa.imem_req_ready;
      ifa.imem_rdata <= memword(ifa.imem_addr);
   end

   always @(posedge clk) begin
      if (rst_b) ifb.imem_rsp_valid <= 1'b0;
      else       ifb.imem_rsp_valid <= ifb.imem_req_valid && ifb.imem_req_ready;
      ifb.imem_rdata <= memword(ifb.imem_addr);
   end

   // Scoreboard: every request and every consumed instruction must match the next expectation
   always @(negedge clk) begin
      if (rst_a === 1'b0 && ifa.imem_req_valid === 1'b1 && ifa.imem_req_ready === 1'b1) begin
         chk("req_expected", 64'(exp_addr_q.size() != 0), 64'(1));
         if (exp_addr_q.size() != 0) chk("req_addr", 64'(ifa.imem_addr), 64'(exp_addr_q.pop_front()));
      end
      if (rst_a === 1'b0 && ifa.inst_valid === 1'b1 && ifa.inst_ready === 1'b1) begin
         chk("inst_expected", 64'(exp_inst_q.size() != 0), 64'(1));
         if (exp_inst_q.size() != 0) begin
            mon_e = exp_inst_q.pop_front();
            chk("inst_word", 64'(ifa.inst), 64'(mon_e[31:0]));
            chk("inst_pc", 64'(ifa.inst_pc), 64'(mon_e[63:32]));
            chk("opcode", 64'(ifa.opcode), 64'(mon_e[6:0]));
            chk("func3", 64'(ifa.func3), 64'(mon_e[14:12]));
            chk("func7_5", 64'(ifa.func7_5), 64'(mon_e[30]));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      ifa.imem_req_ready = 1'b0;
      ifa.inst_ready     = 1'b0;
      ifa.redirect_valid = 1'b0;
      ifa.redirect_pc    = 32'h0;
      ifb.imem_req_ready = 1'b1;
      ifb.inst_ready     = 1'b1;
      ifb.redirect_valid = 1'b0;
      ifb.redirect_pc    = 32'h0;
      repeat (3) @(posedge clk);

      @(negedge clk);
      chk("rst_inst_valid", 64'(ifa.inst_valid), 64'(0));
      chk("rst_inst", 64'(ifa.inst), 64'(0));
      chk("rst_inst_pc", 64'(ifa.inst_pc), 64'(0));
      chk("rst_misaligned", 64'(ifa.redirect_misaligned), 64'(0));
      chk("rst_req_forced_low", 64'(ifa.imem_req_valid), 64'(0));

      // PC wrap from RESET_PC = 0xFFFF_FFFC
      @(posedge clk); #1 rst_b = 1'b0;
      @(negedge clk);
      chk("wrap_req_valid", 64'(ifb.imem_req_valid), 64'(1));
      chk("wrap_first_addr", 64'(ifb.imem_addr), 64'(32'hFFFF_FFFC));
      for (int n = 0; n < 20 && ifb.inst_valid !== 1'b1; n++) @(negedge clk);
      chk("wrap_inst_pc", 64'(ifb.inst_pc), 64'(32'hFFFF_FFFC));
      chk("wrap_inst", 64'(ifb.inst), 64'(memword(32'hFFFF_FFFC)));
      chk("wrap_next_req", 64'(ifb.imem_req_valid), 64'(1));
      chk("wrap_next_addr", 64'(ifb.imem_addr), 64'(32'h0));

      // Memory stall, then decode stall on the first instruction
      exp_addr_q.push_back(32'h0);
      exp_addr_q.push_back(32'h4);
      exp_addr_q.push_back(32'h8);
      exp_inst_q.push_back({32'h0, memword(32'h0)});
      exp_inst_q.push_back({32'h4, memword(32'h4)});
      @(posedge clk); #1 rst_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("memstall_req_valid", 64'(ifa.imem_req_valid), 64'(1));
         chk("memstall_addr", 64'(ifa.imem_addr), 64'(0));
         chk("memstall_no_inst", 64'(ifa.inst_valid), 64'(0));
      end
      @(posedge clk); #1 ifa.imem_req_ready = 1'b1;
      wait_pc("first_inst", 32'h0);
      chk("first_op_i", 64'(ifa.opcode), 64'(OP_I));
      chk("first_op_known", 64'(opcode_known(ifa.opcode)), 64'(1));
      for (int i = 0; i < 5; i++) begin
         chk("stall_inst", 64'(ifa.inst), 64'(32'h0050_0093));
         chk("stall_inst_pc", 64'(ifa.inst_pc), 64'(0));
         chk("stall_valid", 64'(ifa.inst_valid), 64'(1));
         chk("stall_no_req", 64'(ifa.imem_req_valid), 64'(0));
         @(negedge clk);
      end
      @(posedge clk); #1 ifa.inst_ready = 1'b1;
      wait_pc("second_inst", 32'h4);
      chk("second_op_r", 64'(ifa.opcode), 64'(OP_R));

      // Redirect to 0x100 in the same cycle as the request for 0x8
      chk("red1_req_valid", 64'(ifa.imem_req_valid), 64'(1));
      chk("red1_req_addr", 64'(ifa.imem_addr), 64'(32'h8));
      exp_addr_q.push_back(32'h100);
      exp_addr_q.push_back(32'h104);
      exp_inst_q.push_back({32'h100, memword(32'h100)});
      #1;
      ifa.redirect_valid = 1'b1;
      ifa.redirect_pc    = 32'h100;
      @(posedge clk); #1 ifa.redirect_valid = 1'b0;
      @(negedge clk);
      chk("kill_no_req", 64'(ifa.imem_req_valid), 64'(0));
      chk("kill_no_inst", 64'(ifa.inst_valid), 64'(0));
      wait_pc("red1_inst", 32'h100);

      // Redirect to 0x203 in S_WAIT while the response arrives
      @(negedge clk);
      chk("wait_no_req", 64'(ifa.imem_req_valid), 64'(0));
      exp_addr_q.push_back(32'h200);
      exp_addr_q.push_back(32'h204);
      exp_inst_q.push_back({32'h200, memword(32'h200)});
      #1;
      ifa.redirect_valid = 1'b1;
      ifa.redirect_pc    = 32'h203;
      @(posedge clk); #1 ifa.redirect_valid = 1'b0;
      @(negedge clk);
      chk("red2_misaligned", 64'(ifa.redirect_misaligned), 64'(1));
      chk("red2_no_inst", 64'(ifa.inst_valid), 64'(0));
      chk("red2_req_valid", 64'(ifa.imem_req_valid), 64'(1));
      chk("red2_addr", 64'(ifa.imem_addr), 64'(32'h200));
      wait_pc("red2_inst", 32'h200);
      chk("red2_mis_held", 64'(ifa.redirect_misaligned), 64'(1));

      // Reset pulse while waiting on the response for 0x204
      @(negedge clk);
      exp_addr_q.push_back(32'h0);
      #1 rst_a = 1'b1;
      @(posedge clk); #1;
      rst_a = 1'b0;
      ifa.inst_ready = 1'b0;
      @(negedge clk);
      chk("postrst_inst_valid", 64'(ifa.inst_valid), 64'(0));
      chk("postrst_req_valid", 64'(ifa.imem_req_valid), 64'(1));
      chk("postrst_addr", 64'(ifa.imem_addr), 64'(0));
      chk("postrst_misaligned", 64'(ifa.redirect_misaligned), 64'(0));
      wait_pc("postrst_inst", 32'h0);
      chk("postrst_word", 64'(ifa.inst), 64'(32'h0050_0093));
      @(negedge clk);
      chk("postrst_stall_no_req", 64'(ifa.imem_req_valid), 64'(0));

      chk("addr_q_drained", 64'(exp_addr_q.size()), 64'(0));
      chk("inst_q_drained", 64'(exp_inst_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
